// File: rtl/ethernet_axil_initiator.sv
`timescale 1ns/1ps
// ethernet_axil_initiator
//
// Purpose:
//   AXI4-Lite manager that converts a valid/ready request stream
//   (address, write data, write flag, byte mask) into single AXI4-Lite
//   read or write transactions. It returns read data (or write
//   acknowledgements) on a valid/ready response stream. Only one
//   transaction is ever outstanding. This is the host-side counterpart of
//   the Ethernet controller's AXI4-Lite register port.
//
// Configuration macro:
//   ETHERNET_AXIL_INITIATOR_WACK_EN
//     defined   : every write returns one response beat
//                 (data_o = 0, err_o = |bresp).
//     undefined : writes retire silently. Only reads produce response beats,
//                 and a write bresp error is discarded.
//
// Ports:
//   clk_i, reset_i                  clock, asynchronous active-high reset
//   addr_i/data_i/w_i/wmask_i       request fields
//   v_i / ready_and_o               request handshake
//   data_o/err_o                    response payload (held while v_o)
//   v_o / ready_and_i               response handshake
//   m_axil_aw*, m_axil_w*, m_axil_b*, m_axil_ar*, m_axil_r*
//                                   AXI4-Lite manager channels (prot = 0)
//
// Every AXI valid/ready and every response output comes straight from a
// flop. The flops are loaded from the next-state decode, so a channel
// asserts in the first cycle of its state. It deasserts on the clock edge
// of its own handshake.

module ethernet_axil_initiator #(
    parameter int axil_data_width_p = 32,
    parameter int axil_addr_width_p = 32,
    localparam int axil_mask_width_lp = axil_data_width_p >> 3
) (
    input  logic                          clk_i,
    input  logic                          reset_i,

    // request stream
    input  logic [axil_addr_width_p-1:0]  addr_i,
    input  logic [axil_data_width_p-1:0]  data_i,
    input  logic                          w_i,
    input  logic [axil_mask_width_lp-1:0] wmask_i,
    input  logic                          v_i,
    output logic                          ready_and_o,

    // response stream
    output logic [axil_data_width_p-1:0]  data_o,
    output logic                          err_o,
    output logic                          v_o,
    input  logic                          ready_and_i,

    // AXI4-Lite write address channel
    output logic [axil_addr_width_p-1:0]  m_axil_awaddr_o,
    output logic [2:0]                    m_axil_awprot_o,
    output logic                          m_axil_awvalid_o,
    input  logic                          m_axil_awready_i,

    // AXI4-Lite write data channel
    output logic [axil_data_width_p-1:0]  m_axil_wdata_o,
    output logic [axil_mask_width_lp-1:0] m_axil_wstrb_o,
    output logic                          m_axil_wvalid_o,
    input  logic                          m_axil_wready_i,

    // AXI4-Lite write response channel
    input  logic [1:0]                    m_axil_bresp_i,
    input  logic                          m_axil_bvalid_i,
    output logic                          m_axil_bready_o,

    // AXI4-Lite read address channel
    output logic [axil_addr_width_p-1:0]  m_axil_araddr_o,
    output logic [2:0]                    m_axil_arprot_o,
    output logic                          m_axil_arvalid_o,
    input  logic                          m_axil_arready_i,

    // AXI4-Lite read data channel
    input  logic [axil_data_width_p-1:0]  m_axil_rdata_i,
    input  logic [1:0]                    m_axil_rresp_i,
    input  logic                          m_axil_rvalid_i,
    output logic                          m_axil_rready_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        READ  = 3'd3,
        RDATA = 3'd4,
        RESP  = 3'd5
    } state_e;

    state_e state_r;
    state_e state_next_s;

    // per-channel completion flags while in WRITE
    logic aw_done_r;
    logic w_done_r;
    logic aw_done_next_s;
    logic w_done_next_s;

    // registered handshake outputs
    logic ready_r;
    logic awvalid_r;
    logic wvalid_r;
    logic bready_r;
    logic arvalid_r;
    logic rready_r;
    logic v_r;

    // captured request
    logic [axil_addr_width_p-1:0]  addr_r;
    logic [axil_data_width_p-1:0]  wdata_r;
    logic [axil_mask_width_lp-1:0] wstrb_r;

    // captured response
    logic [axil_data_width_p-1:0]  data_r;
    logic                          err_r;

    // handshake strobes
    logic req_hs_s;
    logic resp_hs_s;
    logic aw_hs_s;
    logic w_hs_s;
    logic b_hs_s;
    logic ar_hs_s;
    logic r_hs_s;

    // capture enables from the next-state decode
    logic capture_req_s;
    logic capture_r_s;
`ifdef ETHERNET_AXIL_INITIATOR_WACK_EN
    logic capture_b_s;
`else
    // The write response code has no destination when write acks are off.
    logic unused_bresp_s;
    assign unused_bresp_s = ^m_axil_bresp_i;
`endif

    assign req_hs_s  = v_i & ready_r;
    assign resp_hs_s = v_r & ready_and_i;
    assign aw_hs_s   = awvalid_r & m_axil_awready_i;
    assign w_hs_s    = wvalid_r & m_axil_wready_i;
    assign b_hs_s    = bready_r & m_axil_bvalid_i;
    assign ar_hs_s   = arvalid_r & m_axil_arready_i;
    assign r_hs_s    = rready_r & m_axil_rvalid_i;

    // Next-state and capture-enable decode for the transaction sequencer.
    always_comb begin
        state_next_s   = state_r;
        aw_done_next_s = aw_done_r;
        w_done_next_s  = w_done_r;
        capture_req_s  = 1'b0;
        capture_r_s    = 1'b0;
`ifdef ETHERNET_AXIL_INITIATOR_WACK_EN
        capture_b_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (req_hs_s) begin
                    capture_req_s = 1'b1;
                    if (w_i) begin
                        state_next_s = WRITE;
                    end else begin
                        state_next_s = READ;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                // AW and W retire independently. Leave once both have
                // retired, whether in the same cycle or not.
                aw_done_next_s = aw_done_r | aw_hs_s;
                w_done_next_s  = w_done_r | w_hs_s;
                if (aw_done_next_s && w_done_next_s) begin
                    state_next_s   = WRESP;
                    aw_done_next_s = 1'b0;
                    w_done_next_s  = 1'b0;
                end else begin
                    state_next_s = WRITE;
                end
            end
            WRESP: begin
                if (b_hs_s) begin
`ifdef ETHERNET_AXIL_INITIATOR_WACK_EN
                    capture_b_s  = 1'b1;
                    state_next_s = RESP;
`else
                    state_next_s = IDLE;
`endif
                end else begin
                    state_next_s = WRESP;
                end
            end
            READ: begin
                if (ar_hs_s) begin
                    state_next_s = RDATA;
                end else begin
                    state_next_s = READ;
                end
            end
            RDATA: begin
                if (r_hs_s) begin
                    capture_r_s  = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = RDATA;
                end
            end
            RESP: begin
                if (resp_hs_s) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = RESP;
                end
            end
            default: begin
                state_next_s   = IDLE;
                aw_done_next_s = 1'b0;
                w_done_next_s  = 1'b0;
            end
        endcase
    end

    // State register and write-channel completion flags.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
        end else begin
            state_r   <= state_next_s;
            aw_done_r <= aw_done_next_s;
            w_done_r  <= w_done_next_s;
        end
    end

    // Handshake outputs are registered from the next state. Each one is
    // therefore live in the first cycle of its state, with no decode glitches.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ready_r   <= 1'b0;
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b0;
            bready_r  <= 1'b0;
            arvalid_r <= 1'b0;
            rready_r  <= 1'b0;
            v_r       <= 1'b0;
        end else begin
            ready_r   <= (state_next_s == IDLE);
            awvalid_r <= (state_next_s == WRITE) & ~aw_done_next_s;
            wvalid_r  <= (state_next_s == WRITE) & ~w_done_next_s;
            bready_r  <= (state_next_s == WRESP);
            arvalid_r <= (state_next_s == READ);
            rready_r  <= (state_next_s == RDATA);
            v_r       <= (state_next_s == RESP);
        end
    end

    // Request capture. The fields stay frozen until the next accepted
    // request, so address, data and strobe hold steady while any valid is up.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            addr_r  <= {axil_addr_width_p{1'b0}};
            wdata_r <= {axil_data_width_p{1'b0}};
            wstrb_r <= {axil_mask_width_lp{1'b0}};
        end else if (capture_req_s) begin
            addr_r  <= addr_i;
            wdata_r <= data_i;
            wstrb_r <= wmask_i;
        end
    end

    // Response capture. It holds through any amount of response backpressure.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            data_r <= {axil_data_width_p{1'b0}};
            err_r  <= 1'b0;
        end else if (capture_r_s) begin
            data_r <= m_axil_rdata_i;
            err_r  <= |m_axil_rresp_i;
        end
`ifdef ETHERNET_AXIL_INITIATOR_WACK_EN
        else if (capture_b_s) begin
            data_r <= {axil_data_width_p{1'b0}};
            err_r  <= |m_axil_bresp_i;
        end
`endif
    end

    assign ready_and_o      = ready_r;
    assign data_o           = data_r;
    assign err_o            = err_r;
    assign v_o              = v_r;

    assign m_axil_awaddr_o  = addr_r;
    assign m_axil_awprot_o  = 3'b000;
    assign m_axil_awvalid_o = awvalid_r;

    assign m_axil_wdata_o   = wdata_r;
    assign m_axil_wstrb_o   = wstrb_r;
    assign m_axil_wvalid_o  = wvalid_r;

    assign m_axil_bready_o  = bready_r;

    assign m_axil_araddr_o  = addr_r;
    assign m_axil_arprot_o  = 3'b000;
    assign m_axil_arvalid_o = arvalid_r;

    assign m_axil_rready_o  = rready_r;

endmodule

// File: tb/tb_ethernet_axil_initiator.sv
`timescale 1ns/1ps
// Self-checking bench for ethernet_axil_initiator. A configurable-latency
// AXI4-Lite subordinate with a 16-word memory sits behind the DUT. A plain
// reference memory array predicts read data.
module tb_ethernet_axil_initiator;

    localparam int DW = 32;
    localparam int AW = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;

    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          w;
    logic [MW-1:0] wmask;
    logic          v_in;
    logic          ready_out;
    logic [DW-1:0] data_out;
    logic          err_out;
    logic          v_out;
    logic          ready_in;

    logic [AW-1:0] awaddr;
    logic [2:0]    awprot;
    logic          awvalid;
    logic          awready;
    logic [DW-1:0] wdata_ax;
    logic [MW-1:0] wstrb;
    logic          wvalid;
    logic          wready;
    logic [1:0]    bresp;
    logic          bvalid;
    logic          bready;
    logic [AW-1:0] araddr;
    logic [2:0]    arprot;
    logic          arvalid;
    logic          arready;
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
    logic          rvalid;
    logic          rready;

    ethernet_axil_initiator dut (
        .clk_i(clk), .reset_i(rst),
        .addr_i(addr), .data_i(wdata), .w_i(w), .wmask_i(wmask),
        .v_i(v_in), .ready_and_o(ready_out),
        .data_o(data_out), .err_o(err_out), .v_o(v_out), .ready_and_i(ready_in),
        .m_axil_awaddr_o(awaddr), .m_axil_awprot_o(awprot),
        .m_axil_awvalid_o(awvalid), .m_axil_awready_i(awready),
        .m_axil_wdata_o(wdata_ax), .m_axil_wstrb_o(wstrb),
        .m_axil_wvalid_o(wvalid), .m_axil_wready_i(wready),
        .m_axil_bresp_i(bresp), .m_axil_bvalid_i(bvalid), .m_axil_bready_o(bready),
        .m_axil_araddr_o(araddr), .m_axil_arprot_o(arprot),
        .m_axil_arvalid_o(arvalid), .m_axil_arready_i(arready),
        .m_axil_rdata_i(rdata), .m_axil_rresp_i(rresp),
        .m_axil_rvalid_i(rvalid), .m_axil_rready_o(rready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- subordinate model ----------------
    int aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
    logic [1:0] b_resp_cfg = 2'b00;
    logic [1:0] r_resp_cfg = 2'b00;

    int aw_wait, w_wait, ar_wait, b_wait, r_wait;
    logic aw_got, w_got, b_pend, r_pend;
    logic [AW-1:0] aw_addr_q, r_addr_q;
    logic [DW-1:0] w_data_q;
    logic [MW-1:0] w_strb_q;
    logic [DW-1:0] sub_mem [16];

    logic aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_data;
    logic [MW-1:0] cur_strb;

    assign awready  = awvalid && (aw_wait >= aw_delay);
    assign wready   = wvalid && (w_wait >= w_delay);
    assign arready  = arvalid && (ar_wait >= ar_delay);
    assign bvalid   = b_pend && (b_wait >= b_delay);
    assign rvalid   = r_pend && (r_wait >= r_delay);
    assign bresp    = b_resp_cfg;
    assign rresp    = r_resp_cfg;
    assign rdata    = sub_mem[r_addr_q[5:2]];
    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign ar_hs    = arvalid & arready;
    assign b_hs     = bvalid & bready;
    assign r_hs     = rvalid & rready;
    assign cur_addr = aw_hs ? awaddr : aw_addr_q;
    assign cur_data = w_hs ? wdata_ax : w_data_q;
    assign cur_strb = w_hs ? wstrb : w_strb_q;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_wait <= 0; r_wait <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
            aw_addr_q <= '0; r_addr_q <= '0; w_data_q <= '0; w_strb_q <= '0;
            for (int i = 0; i < 16; i++) sub_mem[i] <= 32'hA500_0000 | 32'(i);
        end else begin
            if (aw_hs) aw_wait <= 0; else if (awvalid) aw_wait <= aw_wait + 1;
            if (w_hs) w_wait <= 0; else if (wvalid) w_wait <= w_wait + 1;
            if (ar_hs) ar_wait <= 0; else if (arvalid) ar_wait <= ar_wait + 1;
            if (aw_hs) begin aw_got <= 1'b1; aw_addr_q <= awaddr; end
            if (w_hs) begin w_got <= 1'b1; w_data_q <= wdata_ax; w_strb_q <= wstrb; end
            if ((aw_hs || aw_got) && (w_hs || w_got)) begin
                for (int i = 0; i < MW; i++)
                    if (cur_strb[i]) sub_mem[cur_addr[5:2]][8*i +: 8] <= cur_data[8*i +: 8];
                aw_got <= 1'b0;
                w_got  <= 1'b0;
                b_pend <= 1'b1;
            end
            if (b_hs) begin b_pend <= 1'b0; b_wait <= 0; end
            else if (b_pend) b_wait <= b_wait + 1;
            if (ar_hs) begin r_pend <= 1'b1; r_addr_q <= araddr; end
            if (r_hs) begin r_pend <= 1'b0; r_wait <= 0; end
            else if (r_pend) r_wait <= r_wait + 1;
        end
    end

    // ---------------- protocol monitor ----------------
    int aw_hs_n = 0, w_hs_n = 0, resp_n = 0, axi_act = 0, hold_viol = 0;
    logic aw_hold = 1'b0, w_hold = 1'b0, ar_hold = 1'b0;
    logic [AW-1:0] aw_hold_addr, ar_hold_addr, last_awaddr;
    logic [DW-1:0] w_hold_data;
    logic [MW-1:0] w_hold_strb, last_wstrb;

    always @(posedge clk) begin
        if (aw_hs) begin aw_hs_n <= aw_hs_n + 1; last_awaddr <= awaddr; end
        if (w_hs) begin w_hs_n <= w_hs_n + 1; last_wstrb <= wstrb; end
        if (v_out && ready_in) resp_n <= resp_n + 1;
        if (awvalid || wvalid || arvalid || bready || rready) axi_act <= axi_act + 1;
        if (!rst && ((aw_hold && (!awvalid || awaddr != aw_hold_addr)) ||
                     (w_hold && (!wvalid || wdata_ax != w_hold_data || wstrb != w_hold_strb)) ||
                     (ar_hold && (!arvalid || araddr != ar_hold_addr))))
            hold_viol <= hold_viol + 1;
        aw_hold <= awvalid && !awready && !rst;
        w_hold  <= wvalid && !wready && !rst;
        ar_hold <= arvalid && !arready && !rst;
        aw_hold_addr <= awaddr;
        ar_hold_addr <= araddr;
        w_hold_data  <= wdata_ax;
        w_hold_strb  <= wstrb;
    end

    // ---------------- reference memory ----------------
    logic [DW-1:0] ref_mem [16];

    function automatic void ref_init();
        for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA500_0000 | 32'(i);
    endfunction

    function automatic void ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        for (int i = 0; i < 4; i++)
            if (m[i]) ref_mem[a[5:2]][8*i +: 8] = d[8*i +: 8];
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem[a[5:2]];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int t = 0;
        while (!ready_out && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) check_eq("ready_timeout", 64'(t), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; v_in = 1'b0; ready_in = 1'b1;
        ref_init();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_ready();
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic wr, input logic [3:0] m);
        @(negedge clk);
        addr = a; wdata = d; w = wr; wmask = m; v_in = 1'b1;
        wait_ready();
        if (wr) ref_write(a, d, m);
        @(negedge clk);
        v_in = 1'b0;
    endtask

    task automatic get_resp(output logic [31:0] d, output logic e, output int rviol);
        int t = 0;
        rviol = 0;
        while (!v_out && t < 100) begin
            if (ready_out) rviol++;
            @(negedge clk);
            t++;
        end
        if (t >= 100) check_eq("resp_timeout", 64'(t), 64'd0);
        if (ready_out) rviol++;
        d = data_out;
        e = err_out;
        @(negedge clk);
    endtask

    logic [31:0] rd_d;
    logic        rd_e;
    int          rv, base_aw, base_w, base_hv, base_act, base_resp, reads;
    logic [31:0] ra, rdv;
    logic [3:0]  rm;
    logic        rw;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        v_in = 1'b0; ready_in = 1'b1; addr = '0; wdata = '0; w = 1'b0; wmask = '0;
        ref_init();

        // reset state
        @(negedge clk);
        check_eq("rst_ctrl", 64'({ready_out, v_out, err_out, awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        check_eq("rst_data", 64'({data_out, awaddr}), 64'd0);
        do_reset();
        check_eq("idle_ready", 64'(ready_out), 64'd1);

        // zero-wait write, cycle by cycle
        @(negedge clk);
        addr = 32'h0000_0010; wdata = 32'hDEAD_BEEF; w = 1'b1; wmask = 4'hF; v_in = 1'b1;
        check_eq("w0_c0_ready", 64'(ready_out), 64'd1);
        ref_write(32'h10, 32'hDEAD_BEEF, 4'hF);
        @(negedge clk);
        v_in = 1'b0;
        check_eq("w0_c1_valids", 64'({awvalid, wvalid, arvalid}), 64'b110);
        check_eq("w0_c1_fields", {awaddr, wdata_ax}, {32'h10, 32'hDEAD_BEEF});
        check_eq("w0_c1_strb_prot", 64'({wstrb, awprot}), 64'({4'hF, 3'b000}));
        @(negedge clk);
        check_eq("w0_c2_bready", 64'({bready, awvalid, wvalid}), 64'b100);
        @(negedge clk);
`ifdef ETHERNET_AXIL_INITIATOR_WACK_EN
        check_eq("w0_c3_ack", 64'({v_out, err_out, data_out}), 64'({1'b1, 1'b0, 32'h0}));
`else
        check_eq("w0_c3_idle", 64'({v_out, ready_out}), 64'b01);
`endif
        wait_ready();

        // AW delayed by 5 cycles, W immediate
        aw_delay = 5;
        base_aw = aw_hs_n; base_w = w_hs_n; base_hv = hold_viol;
        send(32'h0000_0014, 32'hCAFE_F00D, 1'b1, 4'b0011);
        check_eq("awd_c1", 64'({awvalid, wvalid}), 64'b11);
        @(negedge clk);
        check_eq("awd_c2", 64'({awvalid, wvalid}), 64'b10);
        check_eq("awd_addr", 64'(awaddr), 64'h14);
`ifdef ETHERNET_AXIL_INITIATOR_WACK_EN
        get_resp(rd_d, rd_e, rv);
        check_eq("awd_ack", 64'({rd_e, rd_d}), 64'd0);
`endif
        wait_ready();
        check_eq("awd_aw_count", 64'(aw_hs_n - base_aw), 64'd1);
        check_eq("awd_w_count", 64'(w_hs_n - base_w), 64'd1);
        check_eq("awd_hold", 64'(hold_viol - base_hv), 64'd0);
        aw_delay = 0;

        // read with 3 wait cycles
        send(32'h0000_1000, 32'h1234_5678, 1'b1, 4'hF);
`ifdef ETHERNET_AXIL_INITIATOR_WACK_EN
        get_resp(rd_d, rd_e, rv);
`endif
        wait_ready();
        r_delay = 3;
        send(32'h0000_1000, 32'h0, 1'b0, 4'h0);
        get_resp(rd_d, rd_e, rv);
        check_eq("rd_data", 64'(rd_d), 64'h1234_5678);
        check_eq("rd_data_ref", 64'(rd_d), 64'(ref_read(32'h1000)));
        check_eq("rd_err", 64'(rd_e), 64'd0);
        check_eq("rd_ready_low", 64'(rv), 64'd0);
        wait_ready();
        r_delay = 0;

        // SLVERR read with response backpressure
        r_resp_cfg = 2'b10;
        ready_in = 1'b0;
        send(32'h0000_0018, 32'h0, 1'b0, 4'h0);
        get_resp(rd_d, rd_e, rv);
        base_act = axi_act;
        for (int i = 0; i < 4; i++) begin
            check_eq("bp_v", 64'({v_out, ready_out}), 64'b10);
            check_eq("bp_data", 64'(data_out), 64'(ref_read(32'h18)));
            check_eq("bp_err", 64'(err_out), 64'd1);
            @(negedge clk);
        end
        check_eq("bp_no_axi", 64'(axi_act - base_act), 64'd0);
        ready_in = 1'b1;
        @(negedge clk);
        r_resp_cfg = 2'b00;
        wait_ready();

        // asynchronous reset while in RDATA
        r_delay = 20;
        send(32'h0000_001C, 32'h0, 1'b0, 4'h0);
        begin
            int t = 0;
            while (!rready && t < 50) begin @(negedge clk); t++; end
            check_eq("rdata_reached", 64'(rready), 64'd1);
        end
        #2 rst = 1'b1;
        #1;
        check_eq("arst_ctrl", 64'({ready_out, v_out, err_out, awvalid, wvalid, arvalid, bready, rready}), 64'd0);
        check_eq("arst_data", {data_out, araddr}, 64'd0);
        check_eq("arst_wr", {wdata_ax, awaddr}, 64'd0);
        r_delay = 0;
        do_reset();
        send(32'h0000_001C, 32'h0, 1'b0, 4'h0);
        get_resp(rd_d, rd_e, rv);
        check_eq("post_rst_rd", 64'({rd_e, rd_d}), 64'({1'b0, ref_read(32'h1C)}));
        wait_ready();

        // randomized back-to-back traffic
        base_resp = resp_n;
        reads = 0;
        for (int i = 0; i < 10; i++) begin
            aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
            ar_delay = $urandom_range(0, 3); b_delay = $urandom_range(0, 3);
            r_delay = $urandom_range(0, 3);
            ra = ($urandom & 32'hFFFF_FFC0) | (32'($urandom_range(0, 3)) << 2);
            rdv = $urandom;
            rm = 4'($urandom_range(0, 15));
            rw = 1'($urandom_range(0, 1));
            if (i == 0) begin rw = 1'b1; rm = 4'h0; end
            if (i == 1) rw = 1'b0;
            if (rw) begin
                send(ra, rdv, 1'b1, rm);
`ifdef ETHERNET_AXIL_INITIATOR_WACK_EN
                get_resp(rd_d, rd_e, rv);
                check_eq("rnd_ack", 64'({rd_e, rd_d}), 64'd0);
`endif
                wait_ready();
                check_eq("rnd_awaddr", 64'(last_awaddr), 64'(ra));
                check_eq("rnd_wstrb", 64'(last_wstrb), 64'(rm));
            end else begin
                send(ra, 32'h0, 1'b0, 4'h0);
                get_resp(rd_d, rd_e, rv);
                check_eq("rnd_rd", 64'({rd_e, rd_d}), 64'({1'b0, ref_read(ra)}));
                reads++;
                wait_ready();
            end
        end
`ifdef ETHERNET_AXIL_INITIATOR_WACK_EN
        check_eq("rnd_resp_count", 64'(resp_n - base_resp), 64'd10);
`else
        check_eq("rnd_resp_count", 64'(resp_n - base_resp), 64'(reads));
`endif
        check_eq("hold_total", 64'(hold_viol), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
